act_unit: RTL and testbench

In-place, streaming activation engine for the feature-map BRAM between the conv and pool stages. It is the successor to the single-mode ReLU pass and adds four selectable activation modes, a programmable base/length window, and a parametrised BRAM read latency. It is fully pipelined, with one element read and one element written per cycle in steady state. It also reports the post-activation zero count, used for sparsity statistics.

---
 rtl/act_unit.sv | 181 ++++++++++++++++++
 tb/tb_act_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/act_unit.sv
// Streaming in-place activation pass over the feature-map BRAM: read, activate, write back.
// Each element takes one read and one write; the pass reports how many outputs were zero.
//
// state  | meaning
// IDLE   | waiting for start; config is latched and the window is checked here
// ISSUE  | one read per cycle, base_addr .. base_addr+length-1
// DRAIN  | reads are done; waiting for the in-flight elements to be written back
// FINISH | done (and err on a rejected window) pulses for one cycle, then back to IDLE
module act_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int CHANNELS   = 8,
    parameter int IMG_SIZE   = 28,
    parameter int RD_LAT     = 1,
    parameter int LEAK_SHIFT = 3,
    localparam int N  = CHANNELS * IMG_SIZE * IMG_SIZE,
    localparam int AW = (N > 1) ? $clog2(N) : 1
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         start,
    input  logic [1:0]                   mode,
    input  logic [AW-1:0]                base_addr,
    input  logic [AW:0]                  length,
    input  logic signed [DATA_WIDTH-1:0] clamp_max,
    output logic [AW-1:0]                conv_r_addr,
    output logic                         conv_r_en,
    input  logic signed [DATA_WIDTH-1:0] conv_r_q,
    output logic [AW-1:0]                conv_w_addr,
    output logic                         conv_w_en,
    output logic                         conv_w_we,
    output logic signed [DATA_WIDTH-1:0] conv_w_d,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [AW:0]                  zero_count
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_e;

    localparam logic [AW+1:0] N_EXT    = (AW+2)'(N);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);

    state_e                        state_q, state_d;
    logic [1:0]                    mode_q, mode_d;
    logic signed [DATA_WIDTH-1:0]  clamp_q, clamp_d;
    logic [AW-1:0]                 rd_addr_q, rd_addr_d;
    logic [AW:0]                   remain_q, remain_d;
    logic                          err_q, err_d;
    logic [AW:0]                   zero_q, zero_d;
    logic [RD_LAT-1:0]             vld_q, vld_d;
    logic [AW-1:0]                 pipe_addr_q [RD_LAT];
    logic [AW-1:0]                 pipe_addr_d [RD_LAT];
    logic                          w_en_q, w_en_d;
    logic [AW-1:0]                 w_addr_q, w_addr_d;
    logic signed [DATA_WIDTH-1:0]  w_data_q, w_data_d;

    logic                          rd_fire;
    logic [AW+1:0]                 win_end;
    logic                          win_bad;
    logic signed [DATA_WIDTH-1:0]  act_y;

    assign rd_fire = (state_q == ISSUE);
    assign win_end = {2'b00, base_addr} + {1'b0, length};
    assign win_bad = (length == '0) || (win_end > N_EXT);

    // Activation of the element arriving from the BRAM this cycle; all results fit DATA_WIDTH.
    always_comb begin
        act_y = conv_r_q;
        case (mode_q)
            2'd1: begin
                if (conv_r_q[DATA_WIDTH-1]) act_y = '0;
            end
            2'd2: begin
                if (conv_r_q[DATA_WIDTH-1]) act_y = conv_r_q >>> LEAK_SHIFT;
            end
            2'd3: begin
                if (clamp_q[DATA_WIDTH-1] || conv_r_q[DATA_WIDTH-1]) begin
                    act_y = '0;
                end else if (conv_r_q > clamp_q) begin
                    act_y = clamp_q;
                end
            end
            default: act_y = conv_r_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        clamp_d   = clamp_q;
        rd_addr_d = rd_addr_q;
        remain_d  = remain_q;
        err_d     = err_q;
        zero_d    = zero_q;

        if (w_en_q && (w_data_q == '0)) zero_d = zero_q + CNT_ONE;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mode_d    = mode;
                    clamp_d   = clamp_max;
                    rd_addr_d = base_addr;
                    remain_d  = length;
                    zero_d    = '0;
                    err_d     = win_bad;
                    state_d   = win_bad ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                rd_addr_d = rd_addr_q + ADDR_ONE;
                remain_d  = remain_q - CNT_ONE;
                if (remain_q == CNT_ONE) state_d = DRAIN;
            end
            DRAIN: begin
                // The output register may still hold the last element; it retires this cycle.
                if (vld_q == '0) state_d = FINISH;
            end
            FINISH: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        vld_d[0]       = rd_fire;
        pipe_addr_d[0] = rd_addr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i]       = vld_q[i-1];
            pipe_addr_d[i] = pipe_addr_q[i-1];
        end
        w_en_d   = vld_q[RD_LAT-1];
        w_addr_d = vld_q[RD_LAT-1] ? pipe_addr_q[RD_LAT-1] : w_addr_q;
        w_data_d = vld_q[RD_LAT-1] ? act_y : w_data_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mode_q    <= '0;
            clamp_q   <= '0;
            rd_addr_q <= '0;
            remain_q  <= '0;
            err_q     <= 1'b0;
            zero_q    <= '0;
            vld_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= '0;
            w_en_q    <= 1'b0;
            w_addr_q  <= '0;
            w_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            clamp_q   <= clamp_d;
            rd_addr_q <= rd_addr_d;
            remain_q  <= remain_d;
            err_q     <= err_d;
            zero_q    <= zero_d;
            vld_q     <= vld_d;
            for (int i = 0; i < RD_LAT; i++) pipe_addr_q[i] <= pipe_addr_d[i];
            w_en_q    <= w_en_d;
            w_addr_q  <= w_addr_d;
            w_data_q  <= w_data_d;
        end
    end

    assign conv_r_en   = rd_fire;
    assign conv_r_addr = rd_addr_q;
    assign conv_w_en   = w_en_q;
    assign conv_w_we   = w_en_q;
    assign conv_w_addr = w_addr_q;
    assign conv_w_d    = w_data_q;
    assign busy        = (state_q == ISSUE) || (state_q == DRAIN);
    assign done        = (state_q == FINISH);
    assign err         = (state_q == FINISH) && err_q;
    assign zero_count  = zero_q;

endmodule

// File: tb/tb_act_unit.sv
// Bench for act_unit: BRAM model with RD_LAT read pipeline, write scoreboard, directed passes.
module tb_act_unit;
    localparam int DW  = 16;
    localparam int CH  = 8;
    localparam int IMG = 28;
    localparam int RDL = 3;
    localparam int LS  = 3;
    localparam int N   = CH * IMG * IMG;
    localparam int AW  = (N > 1) ? $clog2(N) : 1;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic [1:0]           mode = '0;
    logic [AW-1:0]        base_addr = '0;
    logic [AW:0]          length = '0;
    logic signed [DW-1:0] clamp_max = '0;
    logic [AW-1:0]        conv_r_addr;
    logic                 conv_r_en;
    logic signed [DW-1:0] conv_r_q;
    logic [AW-1:0]        conv_w_addr;
    logic                 conv_w_en;
    logic                 conv_w_we;
    logic signed [DW-1:0] conv_w_d;
    logic                 busy;
    logic                 done;
    logic                 err;
    logic [AW:0]          zero_count;

    logic signed [DW-1:0] img   [N];
    logic signed [DW-1:0] mem   [N];
    logic signed [DW-1:0] rpipe [RDL];
    logic                 load = 1'b0;
    int                   r_cnt = 0;
    int                   w_cnt = 0;
    int                   n_chk = 0;
    int                   n_fail = 0;
    wr_t                  exp_q [$];

    act_unit #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .IMG_SIZE(IMG), .RD_LAT(RDL), .LEAK_SHIFT(LS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .base_addr(base_addr), .length(length), .clamp_max(clamp_max),
        .conv_r_addr(conv_r_addr), .conv_r_en(conv_r_en), .conv_r_q(conv_r_q),
        .conv_w_addr(conv_w_addr), .conv_w_en(conv_w_en), .conv_w_we(conv_w_we),
        .conv_w_d(conv_w_d), .busy(busy), .done(done), .err(err), .zero_count(zero_count)
    );

    always #5 clk = ~clk;

    assign conv_r_q = rpipe[RDL-1];

    always @(posedge clk) begin
        if (load) begin
            for (int i = 0; i < N; i++) mem[i] <= img[i];
        end else if (conv_w_en && conv_w_we) begin
            mem[conv_w_addr] <= conv_w_d;
        end
        rpipe[0] <= conv_r_en ? mem[conv_r_addr] : 16'sh7EAD;
        for (int i = 1; i < RDL; i++) rpipe[i] <= rpipe[i-1];
        if (conv_r_en) r_cnt <= r_cnt + 1;
        if (conv_w_en) w_cnt <= w_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic monitor();
        wr_t  e;
        logic e_we;
        forever begin
            @(negedge clk);
            if (conv_w_en) begin
                e_we = (exp_q.size() > 0);
                e    = e_we ? exp_q.pop_front() : '0;
                n_chk++;
                assert ({conv_w_we, conv_w_addr, conv_w_d} === {e_we, e.a, e.d}) else begin
                    n_fail++;
                    $error("FAIL write: got we=%0b addr=%0d data=%0d, expected we=%0b addr=%0d data=%0d",
                           conv_w_we, conv_w_addr, conv_w_d, e_we, e.a, $signed(e.d));
                end
            end
        end
    endtask

    task automatic push(input int a, input int d);
        exp_q.push_back('{a: AW'(a), d: DW'(d)});
    endtask

    task automatic load_img();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (!done && cyc < c0 + N + 50) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_pass(input logic [1:0] m, input int b, input int l,
                            input logic signed [DW-1:0] cm, input logic exp_err,
                            input int exp_zero, input string tag);
        int cyc;
        int r0;
        int w0;
        int exp_n;
        exp_n = exp_err ? 0 : l;
        r0 = r_cnt;
        w0 = w_cnt;
        mode = m; base_addr = AW'(b); length = (AW+1)'(l); clamp_max = cm; start = 1'b1;
        @(negedge clk);
        start = 1'b0; mode = ~m; base_addr = ~AW'(b); length = '1; clamp_max = ~cm;
        chk({tag, "_busy"}, busy, !exp_err);
        wait_done(1, cyc);
        chk({tag, "_latency"}, cyc, exp_err ? 1 : l + RDL + 2);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_err"}, err, exp_err);
        chk({tag, "_busy_at_done"}, busy, 0);
        chk({tag, "_zero_count"}, zero_count, exp_zero);
        chk({tag, "_pending"}, exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        chk({tag, "_reads"}, r_cnt - r0, exp_n);
        chk({tag, "_writes"}, w_cnt - w0, exp_n);
        chk({tag, "_done_pulse"}, done, 0);
    endtask

    initial begin
        int cyc;
        int w0;
        fork
            monitor();
        join_none

        #3;
        chk("reset_outputs", {busy, done, err, conv_r_en, conv_w_en, conv_w_we,
                              conv_r_addr, conv_w_addr, conv_w_d, zero_count}, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full-map ReLU over alternating +5/-5
        for (int i = 0; i < N; i++) begin
            img[i] = (i % 2 == 0) ? 16'sd5 : -16'sd5;
            push(i, (i % 2 == 0) ? 5 : 0);
        end
        load_img();
        run_pass(2'd1, 0, N, '0, 1'b0, N / 2, "relu_full");
        chk("relu_full_mem1", mem[1], 0);
        chk("relu_full_memlast", mem[N-2], 5);

        // Leaky ReLU window with neighbours that must stay untouched
        img[9] = 16'sd1234; img[10] = -16'sd16; img[11] = -16'sd1;
        img[12] = 16'sd7;   img[13] = 16'sd0;   img[14] = -16'sd77;
        load_img();
        push(10, -2); push(11, -1); push(12, 7); push(13, 0);
        run_pass(2'd2, 10, 4, '0, 1'b0, 1, "leaky");
        chk("leaky_untouched9", mem[9], 1234);
        chk("leaky_untouched14", mem[14], -77);

        // Leaky extremes on the window that ends exactly at N
        img[N-3] = -16'sd32768; img[N-2] = 16'sd32767; img[N-1] = -16'sd9;
        load_img();
        push(N-3, -4096); push(N-2, 32767); push(N-1, -2);
        run_pass(2'd2, N-3, 3, '0, 1'b0, 0, "leaky_edge");

        // Clamped ReLU, then a negative ceiling
        img[40] = -16'sd3; img[41] = 16'sd100; img[42] = 16'sd2000; img[43] = 16'sd1536;
        load_img();
        push(40, 0); push(41, 100); push(42, 1536); push(43, 1536);
        run_pass(2'd3, 40, 4, 16'sd1536, 1'b0, 1, "clamp");
        load_img();
        push(40, 0); push(41, 0); push(42, 0); push(43, 0);
        run_pass(2'd3, 40, 4, -16'sd1, 1'b0, 4, "clamp_neg");

        // Rejected windows: no BRAM traffic, done+err in cycle 1
        run_pass(2'd1, N-2, 3, '0, 1'b1, 0, "bad_window");
        run_pass(2'd1, 5, 0, '0, 1'b1, 0, "zero_len");

        // Reset in the middle of a bypass pass
        load_img();
        for (int i = 0; i < 100; i++) push(i, img[i]);
        mode = 2'd0; base_addr = '0; length = (AW+1)'(100); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("reset_mid_outputs", {busy, done, err, conv_r_en, conv_w_en, conv_w_we,
                                  conv_r_addr, conv_w_addr, conv_w_d, zero_count}, 0);
        exp_q.delete();
        w0 = w_cnt;
        repeat (2) @(negedge clk);
        chk("reset_mid_no_writes", w_cnt - w0, 0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) push(i, (i % 2 == 0) ? 5 : 0);
        run_pass(2'd1, 0, 8, '0, 1'b0, 4, "after_reset");

        // start held high through a pass and its done cycle
        img[20] = -16'sd4; img[21] = 16'sd9; img[22] = 16'sd0;
        load_img();
        for (int k = 0; k < 2; k++) begin
            push(20, -4); push(21, 9); push(22, 0);
        end
        w0 = w_cnt;
        mode = 2'd0; base_addr = AW'(20); length = (AW+1)'(3); clamp_max = '0; start = 1'b1;
        wait_done(0, cyc);
        chk("held_latency1", cyc, 3 + RDL + 2);
        chk("held_busy_at_done", busy, 0);
        @(negedge clk);
        chk("held_idle_gap", busy, 0);
        @(negedge clk);
        chk("held_restart", busy, 1);
        start = 1'b0;
        wait_done(1, cyc);
        chk("held_latency2", cyc, 3 + RDL + 2);
        chk("held_done2", done, 1);
        chk("held_zero_count", zero_count, 1);
        repeat (3) @(negedge clk);
        chk("held_writes", w_cnt - w0, 6);
        chk("held_pending", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
